sa_param_array: RTL and testbench

//  Parametrised weight-stationary systolic array, ROWS x COLS PEs, for the conv datapath.

---
 rtl/sa_pkg.sv | 18 +
 rtl/sa_param_array_if.sv | 21 ++
 rtl/sa_pe_cell.sv | 38 +++
 rtl/sa_param_array.sv | 132 +++++++++++++
 tb/tb_sa_param_array.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared types and constants for the weight-stationary systolic array.
package sa_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sa_state_e;

  localparam int ROWS_DEF = 3;
  localparam int COLS_DEF = 3;
  localparam int LAT      = ROWS_DEF + 2;
  localparam int NW       = ROWS_DEF * COLS_DEF;

  // Replicate bit w-1 of v into every higher bit; callers truncate to the width they need.
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < 64; i++)
      if (i >= w) r[i] = v[w-1];
    return r;
  endfunction
endpackage

// File: rtl/sa_param_array_if.sv
// Weight-load, sample-stream and result bus of the systolic array.
interface sa_param_array_if #(
  parameter int ROWS   = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);
  logic                   w_valid;
  logic                   w_ready;
  logic [DATA_W-1:0]      w_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] in_data;
  logic                   out_valid;
  logic [ACC_W-1:0]       out_data;
  logic                   weights_ok;

  modport master (output w_valid, w_data, in_valid, in_data,
                  input  w_ready, in_ready, out_valid, out_data, weights_ok);
  modport slave  (input  w_valid, w_data, in_valid, in_data,
                  output w_ready, in_ready, out_valid, out_data, weights_ok);
endinterface

// File: rtl/sa_pe_cell.sv
// One PE: registered sample pass-through and registered psum_out = psum_in + w*x.
module sa_pe_cell import sa_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [ACC_W-1:0]  psum_i,
  output logic [DATA_W-1:0] x_o,
  output logic [ACC_W-1:0]  psum_o
);
  logic signed [DATA_W-1:0] w_q;
  logic [DATA_W-1:0]        x_q;
  logic [ACC_W-1:0]         psum_q;
  logic [2*DATA_W-1:0]      prod;
  logic [ACC_W-1:0]         term;

  assign prod = (2*DATA_W)'($signed(w_q)) * (2*DATA_W)'($signed(x_i));
  assign term = ACC_W'(sext(64'(prod), 2*DATA_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q    <= '0;
      x_q    <= '0;
      psum_q <= '0;
    end else begin
      x_q    <= x_i;
      psum_q <= psum_i + term;
      if (load_i) w_q <= w_i;
    end
  end

  assign x_o    = x_q;
  assign psum_o = psum_q;
endmodule

// File: rtl/sa_param_array.sv
// ROWS x COLS weight-stationary systolic array: skewed lanes in, column psums reduced to one result/cycle.
module sa_param_array import sa_pkg::*; #(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(ROWS*COLS)
) (
  input logic              clk,
  input logic              reset,
  sa_param_array_if.slave  bus
);
  localparam int LATENCY = ROWS + 2;
  localparam int NWORDS  = ROWS * COLS;
  localparam int IDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CNT_W   = $clog2(LATENCY + 1);

  sa_state_e                     state_q, state_d;
  logic [IDX_W-1:0]              idx_q;
  logic [NWORDS-1:0][DATA_W-1:0] shadow_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          wok_q;
  logic [LATENCY:1]              vld_pipe;
  logic [ACC_W-1:0]              out_q, sum_d;
  logic                          w_rdy, in_rdy, w_acc, in_acc, w_last, commit;

  assign w_rdy  = (state_q != DRAIN);
  assign in_rdy = (state_q == RUN);
  assign w_acc  = bus.w_valid & w_rdy;
  assign in_acc = bus.in_valid & in_rdy;
  assign w_last = w_acc && (idx_q == IDX_W'(NWORDS - 1));

  // Commit once nothing is pending beyond a result leaving this very cycle.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE, RUN: if (w_last) state_d = DRAIN;
      DRAIN: if (cnt_q == CNT_W'(vld_pipe[LATENCY])) begin
        commit  = 1'b1;
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      wok_q    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      state_q <= state_d;
      if (w_acc) begin
        shadow_q[idx_q] <= bus.w_data;
        idx_q           <= w_last ? '0 : idx_q + 1'b1;
      end
      cnt_q    <= cnt_q + CNT_W'(in_acc) - CNT_W'(vld_pipe[LATENCY]);
      if (commit) wok_q <= 1'b1;
      vld_pipe <= {vld_pipe[LATENCY-1:1], in_acc};
    end
  end

  // Non-accepted cycles inject zeros so bubbles never contribute to a result.
  logic [ROWS-1:0][DATA_W-1:0] x_in, x_row, x_unused;
  always_comb begin
    x_in = '0;
    for (int r = 0; r < ROWS; r++)
      if (in_acc) x_in[r] = bus.in_data[r*DATA_W +: DATA_W];
  end

  logic [ROWS:0][COLS-1:0][ACC_W-1:0]  ps;
  logic [ROWS-1:0][COLS:0][DATA_W-1:0] xs;
  assign ps[0] = '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == 0) begin : g_noskew
      assign x_row[r] = x_in[r];
    end else begin : g_skew
      logic [r-1:0][DATA_W-1:0] sk_q;
      always_ff @(posedge clk) begin
        if (reset) sk_q <= '0;
        else begin
          sk_q[0] <= x_in[r];
          for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign x_row[r] = sk_q[r-1];
    end

    assign xs[r][0]    = x_row[r];
    assign x_unused[r] = xs[r][COLS];

    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe_cell #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk    (clk),
        .reset  (reset),
        .load_i (commit),
        .w_i    (shadow_q[r*COLS + c]),
        .x_i    (xs[r][c]),
        .psum_i (ps[r][c]),
        .x_o    (xs[r][c+1]),
        .psum_o (ps[r+1][c])
      );
    end
  end

  // Column c carries tap c already delayed by c, so a plain column sum is the correlation.
  logic [COLS-1:0][ACC_W-1:0] bot_q;
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < COLS; c++) sum_d = sum_d + bot_q[c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bot_q <= '0;
      out_q <= '0;
    end else begin
      bot_q <= ps[ROWS];
      out_q <= sum_d;
    end
  end

  assign bus.w_ready    = w_rdy;
  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = vld_pipe[LATENCY];
  assign bus.out_data   = out_q;
  assign bus.weights_ok = wok_q;
endmodule

// File: tb/tb_sa_param_array.sv
// Randomized bench for sa_param_array (3x3, 8-bit) with a cycle-indexed correlation model.
module tb_sa_param_array;
  import sa_pkg::*;

  localparam int R  = 3;
  localparam int C  = 3;
  localparam int DW = 8;
  localparam int N  = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sa_param_array_if #(.ROWS(R), .DATA_W(DW), .ACC_W(20)) ifa();
  sa_param_array_if #(.ROWS(R), .DATA_W(DW), .ACC_W(16)) ifb();
  assign ifb.w_valid  = ifa.w_valid;
  assign ifb.w_data   = ifa.w_data;
  assign ifb.in_valid = ifa.in_valid;
  assign ifb.in_data  = ifa.in_data;

  sa_param_array #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(20)) dut (
    .clk(clk), .reset(reset), .bus(ifa));
  sa_param_array #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .bus(ifb));

  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @cyc", tag, got, exp);
    end
  endtask

  // Reference model: X history per cycle, y(t) from the weight set in force at that accept.
  int cyc = 0, rst_cyc = 0;
  logic [R*DW-1:0] xh [N];
  bit              acc_h [N];
  int              y_h [N];
  int              wact [R*C];
  int              wpend [R*C];
  bit              pend_v = 1'b0;
  int              wq [$];
  int              mt, my, ms;
  bit              mev, mia, mwa;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      rst_cyc = cyc;
      wq.delete();
      pend_v = 1'b0;
      for (int i = 0; i < R*C; i++) wact[i] = 0;
    end else begin
      mt  = cyc - LAT;
      mev = (mt > rst_cyc) ? acc_h[mt % N] : 1'b0;
      check("ovalid",   32'(ifa.out_valid), 32'(mev));
      check("ovalid16", 32'(ifb.out_valid), 32'(mev));
      if (mev) begin
        check("ydata",   32'(ifa.out_data), y_h[mt % N] & 32'h000F_FFFF);
        check("ydata16", 32'(ifb.out_data), y_h[mt % N] & 32'h0000_FFFF);
      end
      mia = ifa.in_valid && ifa.in_ready;
      mwa = ifa.w_valid && ifa.w_ready;
      if (mia && pend_v) begin
        wact   = wpend;
        pend_v = 1'b0;
      end
      xh[cyc % N]    = mia ? ifa.in_data : '0;
      acc_h[cyc % N] = mia;
      my = 0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          ms = cyc - c;
          if (ms > rst_cyc) my += wact[r*C + c] * int'($signed(xh[ms % N][r*DW +: DW]));
        end
      y_h[cyc % N] = my;
      if (mwa) begin
        wq.push_back(int'($signed(ifa.w_data)));
        if (wq.size() == R*C) begin
          for (int i = 0; i < R*C; i++) wpend[i] = wq[i];
          pend_v = 1'b1;
          wq.delete();
        end
      end
    end
  end

  // Snapshot of the DUT taken at the negedge of each driven cycle.
  bit          s_wa, s_ia, s_ov, s_ir, s_wr, s_ok;
  logic [31:0] s_od, s_od16;
  int          s_c;
  logic [7:0]  wbuf [R*C];

  task automatic drive(input bit wv, input logic [7:0] wd, input bit iv, input logic [23:0] id);
    ifa.w_valid = wv; ifa.w_data = wd; ifa.in_valid = iv; ifa.in_data = id;
    @(negedge clk);
    s_c  = cyc;
    s_wa = wv && ifa.w_ready;
    s_ia = iv && ifa.in_ready;
    s_ov = ifa.out_valid;  s_ir = ifa.in_ready;
    s_wr = ifa.w_ready;    s_ok = ifa.weights_ok;
    s_od = 32'(ifa.out_data);
    s_od16 = 32'(ifb.out_data);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h0, 1'b0, 24'h0);
  endtask

  task automatic load_w(input bit strm);
    int k = 0, g = 0;
    while (k < R*C && g < 100) begin
      drive(1'b1, wbuf[k], strm, 24'($urandom));
      if (strm) check("run_in_ready", 32'(s_ir), 32'd1);
      if (s_wa) k++;
      g++;
    end
    check("wload_done", 32'(k), 32'(R*C));
  endtask

  task automatic wait_run();
    int n = 0;
    do begin
      idle();
      n++;
    end while (!s_ir && n < 40);
    check("drain_back", 32'(s_ir), 32'd1);
    check("drain_len",  32'((n-1) >= 1 && (n-1) <= LAT), 32'd1);
    check("weights_ok", 32'(s_ok), 32'd1);
  endtask

  task automatic stream(input int n, input bit holes);
    for (int i = 0; i < n; i++)
      drive(1'b0, 8'h0, holes ? ($urandom_range(3) != 0) : 1'b1, 24'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, g;
    ifa.w_valid = 0; ifa.w_data = '0; ifa.in_valid = 0; ifa.in_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset / idle state
    idle();
    check("rst_out_valid",  32'(s_ov), 32'd0);
    check("rst_out_data",   s_od,      32'd0);
    check("rst_in_ready",   32'(s_ir), 32'd0);
    check("rst_weights_ok", 32'(s_ok), 32'd0);
    check("rst_w_ready",    32'(s_wr), 32'd1);

    // single impulse through all-ones kernel
    for (int i = 0; i < R*C; i++) wbuf[i] = 8'd1;
    load_w(1'b0);
    wait_run();
    g = 0;
    do begin
      drive(1'b0, 8'h0, 1'b1, 24'h030201);
      g++;
    end while (!s_ia && g < 20);
    check("t2_accept", 32'(s_ia), 32'd1);
    t0 = s_c;
    for (int k = 1; k <= 8; k++) begin
      idle();
      check("t2_cycle", 32'(s_c), 32'(t0 + k));
      check("t2_ov", 32'(s_ov), 32'(k == 5));
      if (k >= 5 && k <= 7) check("t2_od", s_od, 32'd6);
    end

    // graded kernel, ramp stream back-to-back
    for (int i = 0; i < R*C; i++) wbuf[i] = 8'(i + 1);
    load_w(1'b0);
    wait_run();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 8'h0, 1'b1, {8'(k), 8'(k), 8'(k)});
      check("t3_accept", 32'(s_ia), 32'd1);
    end
    for (int k = 0; k < LAT + 3; k++) begin
      idle();
      if (k < 5) check("t3_burst", 32'(s_ov), 32'd1);
    end

    // signed extremes, full and wrapped accumulator
    for (int i = 0; i < R*C; i++) wbuf[i] = 8'h80;
    load_w(1'b0);
    wait_run();
    for (int k = 0; k < 3; k++) drive(1'b0, 8'h0, 1'b1, 24'h808080);
    t0 = s_c;
    repeat (LAT) idle();
    check("t4_cycle",  32'(s_c), 32'(t0 + LAT));
    check("t4_full",   s_od,   32'd147456);
    check("t4_wrap16", s_od16, 32'd16384);
    repeat (3) idle();

    // random reload while streaming
    for (int i = 0; i < R*C; i++) wbuf[i] = 8'($urandom);
    stream(10, 1'b1);
    load_w(1'b1);
    wait_run();
    stream(20, 1'b1);
    for (int i = 0; i < R*C; i++) wbuf[i] = 8'($urandom);
    stream(6, 1'b0);
    load_w(1'b1);
    wait_run();
    stream(15, 1'b1);
    repeat (LAT + 2) idle();

    // reset with results in flight and a partial weight load
    for (int i = 0; i < R*C; i++) wbuf[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) drive(1'b1, wbuf[i], 1'b1, 24'($urandom));
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      idle();
      check("t6_no_ov", 32'(s_ov), 32'd0);
    end
    check("t6_in_ready", 32'(s_ir), 32'd0);
    check("t6_w_ready",  32'(s_wr), 32'd1);
    check("t6_wok",      32'(s_ok), 32'd0);
    for (int i = 0; i < R*C; i++) wbuf[i] = 8'($urandom);
    for (int i = 0; i < R*C - 1; i++) begin
      drive(1'b1, wbuf[i], 1'b0, 24'h0);
      check("t6_w_acc", 32'(s_wa), 32'd1);
    end
    idle();
    check("t6_partial_ir", 32'(s_ir), 32'd0);
    drive(1'b1, wbuf[R*C-1], 1'b0, 24'h0);
    wait_run();
    stream(8, 1'b0);
    stream(8, 1'b1);
    repeat (LAT + 2) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
